// File: rtl/spram_req_port_pkg.sv
// Shared helpers for the spram_req_port slice: FIFO operation encoding and
// width calculations used by both the top level and the response FIFO.
package spram_req_port_pkg;

  // {pop, push} packed into one selector for the FIFO bookkeeping case.
  typedef enum logic [1:0] {
    FIFO_HOLD = 2'b00,
    FIFO_PUSH = 2'b01,
    FIFO_POP  = 2'b10,
    FIFO_BOTH = 2'b11
  } fifo_op_e;

  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/spram_rsp_fifo.sv
// Small register FIFO holding captured RAM read data until the consumer takes
// it. Pointers wrap modulo RSP_DEPTH, so non-power-of-two depths work.
module spram_rsp_fifo
  import spram_req_port_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int RSP_DEPTH  = 3,
  localparam int CNT_W      = count_width(RSP_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [CNT_W-1:0]      count,
  output logic [DATA_WIDTH-1:0] head
);

  localparam int               PTR_W    = ptr_width(RSP_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RSP_DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [RSP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  pop_eff;
  fifo_op_e              op;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Storage carries no reset: an entry is only ever read after being written.
  for (genvar gi = 0; gi < RSP_DEPTH; gi++) begin : g_entry
    always_comb begin
      mem_d[gi] = mem_q[gi];
      if (push && (wr_ptr_q == PTR_W'(gi))) begin
        mem_d[gi] = push_data;
      end
    end

    always_ff @(posedge clk) begin
      mem_q[gi] <= mem_d[gi];
    end
  end

  always_comb begin
    pop_eff  = pop && (count_q != '0);
    op       = fifo_op_e'({pop_eff, push});
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    unique case (op)
      FIFO_PUSH: begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
        count_d  = count_q + CNT_W'(1);
      end
      FIFO_POP: begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
        count_d  = count_q - CNT_W'(1);
      end
      FIFO_BOTH: begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // The upstream credit rule must make these unreachable.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    push |-> (count_q != CNT_W'(RSP_DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    pop |-> (count_q != '0));

endmodule

// File: rtl/spram_req_port.sv
// Valid/ready request front-end for single_port_ram: drives the RAM pins,
// captures the one-cycle-latency read data and returns it in order.
module spram_req_port
  import spram_req_port_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8,
  parameter int RSP_DEPTH  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  input  logic [DATA_WIDTH-1:0] ram_out
);

  localparam int CNT_W = count_width(RSP_DEPTH);

  logic                  rd_pend_q, rd_pend_d;
  logic                  acc, rd_acc, wr_acc;
  logic                  fifo_pop;
  logic [CNT_W-1:0]      fifo_count;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [CNT_W:0]        credit_used;

  // Credits count both stored responses and the read whose data is still in
  // the RAM output register, so a capture can never find the FIFO full.
  always_comb begin
    credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, rd_pend_q};
    req_ready   = ~reset & (credit_used < (CNT_W + 1)'(RSP_DEPTH));
    acc         = req_valid & req_ready;
    rd_acc      = acc & ~req_we;
    wr_acc      = acc & req_we;
    ram_we      = wr_acc & ~reset;
    ram_addr    = req_addr;
    ram_data    = req_data;
    rd_pend_d   = rd_acc;
    rsp_valid   = ~reset & (fifo_count != '0);
    rsp_data    = fifo_head;
    fifo_pop    = rsp_valid & rsp_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_q <= 1'b0;
    end else begin
      rd_pend_q <= rd_pend_d;
    end
  end

  // ram_out is only meaningful the cycle after a read accept.
  spram_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .RSP_DEPTH  (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rd_pend_q),
    .push_data (ram_out),
    .pop       (fifo_pop),
    .count     (fifo_count),
    .head      (fifo_head)
  );

endmodule

// File: tb/tb_spram_req_port.sv
// Bench for spram_req_port with a behavioural single_port_ram alongside it:
// a directed vector table, hand-built corner sequences and random traffic.
module tb_spram_req_port;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 3;

  logic          clk = 1'b0;
  logic          reset, req_valid, req_we, rsp_ready;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          req_ready, rsp_valid, ram_we;
  logic [DW-1:0] rsp_data, ram_data, ram_out;
  logic [AW-1:0] ram_addr;

  always #5 clk = ~clk;

  spram_req_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data), .ram_out(ram_out)
  );

  // single_port_ram stand-in: registered read, write on we.
  logic [DW-1:0] ram_mem [16];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_data;
    ram_out <= ram_mem[ram_addr];
  end

  // Reference model: memory image plus a queue of accepted, unconsumed reads.
  typedef struct { logic [DW-1:0] data; int e; } pend_t;
  pend_t         mq[$];
  logic [DW-1:0] shadow [16];
  logic [DW-1:0] obs[$];
  int            obs_e[$];
  int            ecnt = 0;
  int            vectors = 0, miscompares = 0;
  bit            exp_ready, exp_valid;

  typedef struct {
    bit rst, v, we; logic [AW-1:0] a; logic [DW-1:0] d; bit rr;
    bit e_rdy, e_vld; logic [DW-1:0] e_dat; bit e_we;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", nm, ecnt, act, exp);
    end
  endtask

  task automatic add(input bit rst, v, we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input bit rr, e_rdy, e_vld, input logic [DW-1:0] e_dat, input bit e_we);
    tbl.push_back(vec_t'{rst, v, we, a, d, rr, e_rdy, e_vld, e_dat, e_we});
  endtask

  // Apply inputs for the coming edge and check outputs against the model.
  task automatic drive(input bit rst, v, we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit rr);
    reset = rst; req_valid = v; req_we = we; req_addr = a; req_data = d; rsp_ready = rr;
    #1;
    exp_ready = !rst && (mq.size() < DEPTH);
    exp_valid = !rst && (mq.size() > 0) && (mq[0].e + 2 <= ecnt);
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
    if (exp_valid) chk("rsp_data", 32'(rsp_data), 32'(mq[0].data));
    chk("ram_we", 32'(ram_we), 32'(v && we && exp_ready));
    if (rsp_valid && rsp_ready && !reset) begin
      obs.push_back(rsp_data);
      obs_e.push_back(ecnt);
    end
  endtask

  task automatic tick();
    bit acc;
    acc = req_valid && exp_ready;
    if (reset) begin
      mq.delete();
    end else begin
      if (exp_valid && rsp_ready) void'(mq.pop_front());
      if (acc && req_we) shadow[req_addr] = req_data;
      if (acc && !req_we) mq.push_back(pend_t'{shadow[req_addr], ecnt});
    end
    @(posedge clk);
    ecnt++;
    #1;
  endtask

  task automatic idle(input int n, input bit rr);
    for (int k = 0; k < n; k++) begin
      drive(1'b0, 1'b0, 1'b0, '0, '0, rr);
      tick();
    end
  endtask

  task automatic chk_obs(input string nm, input logic [DW-1:0] first, input int n);
    chk({nm, "_count"}, 32'(obs.size()), 32'(n));
    for (int k = 0; k < n && k < obs.size(); k++)
      chk({nm, "_data"}, 32'(obs[k]), 32'(first + DW'(k)));
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin : main
    int idx;
    for (int i = 0; i < 16; i++) begin
      ram_mem[i] = DW'(8'hE0 + i);
      shadow[i]  = DW'(8'hE0 + i);
    end

    // rst v we a d rr | rdy vld data we
    add(1,0,0,4'd0,8'h00,1, 0,0,8'h00,0);
    add(1,1,1,4'd3,8'h77,1, 0,0,8'h00,0);  // write during reset is blocked
    add(0,1,1,4'd3,8'hA5,1, 1,0,8'h00,1);  // basic write
    add(0,1,0,4'd3,8'h00,1, 1,0,8'h00,0);  // read accept N
    add(0,0,0,4'd0,8'h00,1, 1,0,8'h00,0);
    add(0,0,0,4'd0,8'h00,1, 1,1,8'hA5,0);  // valid after N+1
    add(0,0,0,4'd0,8'h00,1, 1,0,8'h00,0);
    add(0,1,1,4'd7,8'h3C,1, 1,0,8'h00,1);  // write then immediate read
    add(0,1,0,4'd7,8'h00,1, 1,0,8'h00,0);
    add(0,0,0,4'd0,8'h00,1, 1,0,8'h00,0);
    add(0,0,0,4'd0,8'h00,1, 1,1,8'h3C,0);
    add(0,0,0,4'd0,8'h00,1, 1,0,8'h00,0);
    add(0,1,0,4'd3,8'h00,0, 1,0,8'h00,0);  // read, then reset mid-flight
    add(1,0,0,4'd0,8'h00,1, 0,0,8'h00,0);
    add(0,0,0,4'd0,8'h00,1, 1,0,8'h00,0);
    add(0,0,0,4'd0,8'h00,1, 1,0,8'h00,0);
    add(0,1,0,4'd3,8'h00,1, 1,0,8'h00,0);  // RAM contents survive reset
    add(0,0,0,4'd0,8'h00,1, 1,0,8'h00,0);
    add(0,0,0,4'd0,8'h00,1, 1,1,8'hA5,0);
    add(0,0,0,4'd0,8'h00,1, 1,0,8'h00,0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].v, tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].rr);
      chk("tbl_req_ready", 32'(req_ready), 32'(tbl[i].e_rdy));
      chk("tbl_rsp_valid", 32'(rsp_valid), 32'(tbl[i].e_vld));
      if (tbl[i].e_vld) chk("tbl_rsp_data", 32'(rsp_data), 32'(tbl[i].e_dat));
      chk("tbl_ram_we", 32'(ram_we), 32'(tbl[i].e_we));
      tick();
    end

    // Streaming: 16 writes then 16 back-to-back reads.
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 1'b1, AW'(i), DW'(8'h10 + i), 1'b1);
      tick();
    end
    obs.delete(); obs_e.delete();
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 1'b0, AW'(i), '0, 1'b1);
      chk("stream_req_ready", 32'(req_ready), 32'd1);
      tick();
    end
    idle(4, 1'b1);
    chk_obs("stream", 8'h10, 16);
    for (int k = 1; k < obs_e.size(); k++)
      chk("stream_rate", 32'(obs_e[k] - obs_e[k-1]), 32'd1);

    // Back-pressure: 5 reads offered with rsp_ready low.
    obs.delete(); obs_e.delete();
    idx = 0;
    for (int c = 0; c < 8 && idx < 5; c++) begin
      drive(1'b0, 1'b1, 1'b0, AW'(idx), '0, 1'b0);
      if (exp_ready) idx++;
      tick();
    end
    chk("bp_accepted", 32'(idx), 32'd3);
    drive(1'b0, 1'b1, 1'b0, AW'(idx), '0, 1'b0);
    chk("bp_req_ready_low", 32'(req_ready), 32'd0);
    tick();
    for (int c = 0; c < 30 && idx < 5; c++) begin
      drive(1'b0, 1'b1, 1'b0, AW'(idx), '0, 1'b1);
      if (exp_ready) idx++;
      tick();
    end
    chk("bp_all_accepted", 32'(idx), 32'd5);
    idle(5, 1'b1);
    chk_obs("bp", 8'h10, 5);

    // Push and pop together with count 2 and a read in flight.
    obs.delete(); obs_e.delete();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, AW'(8 + i), '0, 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    chk("full_rsp_valid", 32'(rsp_valid), 32'd1);
    tick();
    idle(5, 1'b1);
    chk_obs("pushpop", 8'h18, 3);

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 99) == 0, ($urandom % 4) != 0, ($urandom % 3) == 0,
            AW'($urandom), DW'($urandom), ($urandom % 4) != 0);
      tick();
    end
    idle(6, 1'b1);
    chk("final_drain_empty", 32'(rsp_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
